apb_cmd_master: RTL
===================

Name: apb_cmd_master

Overview:
- Hardware APB initiator. Converts a valid/ready command stream (addr, wdata, write flag) into APB3 transfers toward slave ports such as apb_input_buffer_port.
- Returns one response per transfer (read data or write ack) on a valid/ready response channel.
- Sits between the on-chip sequencer/DMA and the APB configuration/packet ports. Replaces software-driven APB access for token/program config, packet words and OPU payload reads.

Parameters:
- BUS_AW, 6, APB address width
- BUS_DW, 32, APB data width
- CMD_FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥2
- TIMEOUT_CYCLES, 255, ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cmd_vld_i  in  1  command valid
- cmd_rdy_o  out  1  command ready (FIFO not full)
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  BUS_AW  target address
- cmd_wdata_i  in  BUS_DW  write data; ignored for reads
- rsp_vld_o  out  1  response valid
- rsp_rdy_i  in  1  response ready
- rsp_write_o  out  1  echoed write flag
- rsp_rdata_o  out  BUS_DW  read data; 0 for writes
- rsp_err_o  out  1  transfer aborted by timeout
- apb_paddr_m  out  BUS_AW  APB address
- apb_pwrite_m  out  1  APB write
- apb_psel_m  out  1  APB select
- apb_penable_m  out  1  APB enable
- apb_pwdata_m  out  BUS_DW  APB write data
- apb_prdata_m  in  BUS_DW  APB read data
- apb_pready_m  in  1  APB ready
- busy_o  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE, FIFO flushed (rd/wr ptr=0, count=0). All outputs 0 except cmd_rdy_o=0 while rst_i is high and 1 on the first cycle after release. A transfer in flight is dropped with no response.
- Command FIFO:
  - Push on cmd_vld_i&&cmd_rdy_o. cmd_rdy_o = (count != CMD_FIFO_DEPTH).
  - Pop when the FSM enters SETUP.
  - Simultaneous push+pop when full is not allowed: cmd_rdy_o stays 0 when full. Pointers wrap modulo depth. Count width is $clog2(CMD_FIFO_DEPTH)+1.
- FSM states IDLE, SETUP, ACCESS, RESP. APB outputs are registered and decoded from state plus the latched command.
  - IDLE: if FIFO non-empty, latch head into addr/write/wdata regs, pop, go to SETUP.
  - SETUP: psel=1, penable=0, paddr/pwrite/pwdata valid. Lasts exactly 1 cycle, then ACCESS.
  - ACCESS: psel=1, penable=1, address/data held stable. At the rising edge where apb_pready_m=1, capture apb_prdata_m (reads only; writes capture 0), go to RESP, drop psel/penable.
  - RESP: rsp_vld_o=1; rsp_write_o/rsp_rdata_o/rsp_err_o stable until handshake. On rsp_rdy_i: if FIFO non-empty, latch+pop and go to SETUP directly; else go to IDLE.
- Single outstanding transfer; no new SETUP while rsp_vld_o=1 and unaccepted.
- Latency: command pushed at edge N into an empty FIFO while IDLE → psel_m high in cycle N+2. With zero-wait pready and rsp_rdy_i=1, back-to-back transfers issue every 3 cycles (SETUP, ACCESS, RESP).
- paddr/pwrite/pwdata hold their last value outside transfers; psel/penable are 0 outside transfers.
- pready is ignored outside ACCESS.
- busy_o = (state!=IDLE) || (count!=0).

Optional Feature:
- Macro: APB_TIMEOUT_EN
- Defined:
  - A counter clears on SETUP entry and increments each ACCESS cycle.
  - If it reaches TIMEOUT_CYCLES with pready still 0, the transfer aborts: psel/penable drop to 0 and the FSM goes to RESP with rsp_err_o=1 and rsp_rdata_o=32'hDEAD_BEEF.
  - pready=1 in the same cycle as the limit counts as success (err=0).
- Not defined: no counter. ACCESS waits indefinitely for pready; rsp_err_o is tied to 0.

Test Plan:
- Write addr 6'h00 data 32'h0000_1234, pready=1 → psel high 1 cycle before penable; pwdata=32'h1234. Response has write=1, rdata=0, err=0.
- Read addr 6'h3C; pready held low 3 ACCESS cycles, then high with prdata=32'h1 → penable high 4 cycles; rsp_rdata_o=32'h1; paddr stable throughout.
- Push 5 commands back-to-back with rsp_rdy_i=0 → cmd_rdy_o low after 4 entries accepted plus one latched. Exactly one APB transfer occurs until the response is accepted; with rsp_rdy_i=1, the remaining transfers issue with a 3-cycle cadence.
- Response backpressure: hold rsp_rdy_i=0 for 10 cycles after a read → rsp fields stable, no new psel.
- Assert rst_i during ACCESS → psel/penable/rsp_vld 0 immediately. FIFO empty; busy_o=0; no stale response after release.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready stuck 0 → psel drops after 8 ACCESS cycles; rsp_err_o=1, rsp_rdata_o=32'hDEAD_BEEF. The next queued command then proceeds normally.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command/response streams plus APB3 bus of apb_cmd_master.
// Ports: master = initiator (apb_cmd_master), slave = environment (sequencer + APB slave).
interface apb_cmd_master_if #(
    parameter int BUS_AW = 6,
    parameter int BUS_DW = 32
);
    logic              cmd_vld_i;
    logic              cmd_rdy_o;
    logic              cmd_write_i;
    logic [BUS_AW-1:0] cmd_addr_i;
    logic [BUS_DW-1:0] cmd_wdata_i;
    logic              rsp_vld_o;
    logic              rsp_rdy_i;
    logic              rsp_write_o;
    logic [BUS_DW-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic [BUS_AW-1:0] apb_paddr_m;
    logic              apb_pwrite_m;
    logic              apb_psel_m;
    logic              apb_penable_m;
    logic [BUS_DW-1:0] apb_pwdata_m;
    logic [BUS_DW-1:0] apb_prdata_m;
    logic              apb_pready_m;

    modport master (
        input  cmd_vld_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  rsp_rdy_i, apb_prdata_m, apb_pready_m,
        output cmd_rdy_o, rsp_vld_o, rsp_write_o, rsp_rdata_o, rsp_err_o,
        output apb_paddr_m, apb_pwrite_m, apb_psel_m, apb_penable_m,
        output apb_pwdata_m
    );

    modport slave (
        output cmd_vld_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output rsp_rdy_i, apb_prdata_m, apb_pready_m,
        input  cmd_rdy_o, rsp_vld_o, rsp_write_o, rsp_rdata_o, rsp_err_o,
        input  apb_paddr_m, apb_pwrite_m, apb_psel_m, apb_penable_m,
        input  apb_pwdata_m
    );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: command FIFO + APB3 initiator FSM, one response per transfer.
// Ports: clk_i, rst_i (async, active-high), bus (apb_cmd_master_if.master:
//   cmd stream, rsp stream, APB3 bus), busy_o (FSM active or FIFO non-empty).
// Option: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles.
module apb_cmd_master #(
    parameter int BUS_AW         = 6,
    parameter int BUS_DW         = 32,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    apb_cmd_master_if.master bus,
    output logic             busy_o
);
    localparam int PW = $clog2(CMD_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + BUS_AW + BUS_DW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [EW-1:0]     r_mem [CMD_FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_state;
    logic [BUS_AW-1:0] r_paddr;
    logic              r_pwrite;
    logic [BUS_DW-1:0] r_pwdata;
    logic              r_psel;
    logic              r_penable;
    logic              r_rsp_vld;
    logic              r_rsp_write;
    logic [BUS_DW-1:0] r_rsp_rdata;

    logic              w_push;
    logic              w_pop;
    logic              w_nempty;
    logic [EW-1:0]     w_head;

    assign bus.cmd_rdy_o = !rst_i && (r_count != CW'(CMD_FIFO_DEPTH));
    assign w_push        = bus.cmd_vld_i && bus.cmd_rdy_o;
    assign w_nempty      = (r_count != '0);
    assign w_head        = r_mem[r_rptr];

    // The head is consumed exactly when a new SETUP is entered: from IDLE,
    // or straight from RESP once the response has been accepted.
    assign w_pop = w_nempty &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_RESP) && bus.rsp_rdy_i));

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wptr] <= {bus.cmd_write_i, bus.cmd_addr_i, bus.cmd_wdata_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] r_tcnt;
    logic           r_rsp_err;
    logic           w_tmo;

    // Last allowed ACCESS cycle with pready still low.
    assign w_tmo = (r_state == S_ACCESS) && !bus.apb_pready_m &&
                   (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_tcnt <= '0;
        else if (w_pop)
            r_tcnt <= '0;
        else if (r_state == S_ACCESS)
            r_tcnt <= r_tcnt + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_rsp_err <= 1'b0;
        else if (r_state == S_ACCESS && (bus.apb_pready_m || w_tmo))
            r_rsp_err <= w_tmo;
    end

    assign bus.rsp_err_o = r_rsp_err;
`else
    logic w_tmo;
    logic w_unused_tmo;

    assign w_tmo         = 1'b0;
    assign w_unused_tmo  = ^TIMEOUT_CYCLES;
    assign bus.rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_nempty) begin
                        r_state <= S_SETUP;
                        r_psel  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (bus.apb_pready_m || w_tmo) begin
                        r_state     <= S_RESP;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_vld   <= 1'b1;
                        r_rsp_write <= r_pwrite;
                        if (w_tmo)
                            r_rsp_rdata <= BUS_DW'(32'hDEAD_BEEF);
                        else if (r_pwrite)
                            r_rsp_rdata <= '0;
                        else
                            r_rsp_rdata <= bus.apb_prdata_m;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_rdy_i) begin
                        r_rsp_vld <= 1'b0;
                        if (w_nempty) begin
                            r_state <= S_SETUP;
                            r_psel  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
            if (w_pop)
                {r_pwrite, r_paddr, r_pwdata} <= w_head;
        end
    end

    assign bus.apb_paddr_m   = r_paddr;
    assign bus.apb_pwrite_m  = r_pwrite;
    assign bus.apb_pwdata_m  = r_pwdata;
    assign bus.apb_psel_m    = r_psel;
    assign bus.apb_penable_m = r_penable;
    assign bus.rsp_vld_o     = r_rsp_vld;
    assign bus.rsp_write_o   = r_rsp_write;
    assign bus.rsp_rdata_o   = r_rsp_rdata;

    assign busy_o = (r_state != S_IDLE) || w_nempty;
endmodule
